vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA raster timing generator; next generation of the fixed 640x480 driver.
//  Runs in the single system clock domain, advancing one pixel per pixEn strobe, so no PLL is needed.
//  Delays sync, valid and coordinates by DELAY pixel ticks to line up with pipelined video generators.
//  Adds one-cycle start-of-frame and end-of-line strobes, and an optional frame counter.
// PARAMETERS
//  H_AV 640 / H_FP 16 / H_SP 96 / H_BP 48 : horizontal active, front porch, sync, back porch (pixels)
//  V_AV 480 / V_FP 10 / V_SP 2  / V_BP 33 : vertical active, front porch, sync, back porch (lines)
//  H_POL 0 : hSync active level (0 = active-low)
//  V_POL 0 : vSync active level (0 = active-low)
//  DELAY 1 : output pipeline depth in pixel ticks, legal range 1..8
//  CW 10   : x/y width; must hold H_TOTAL-1 and V_TOTAL-1
//  FW 8    : frameCnt width
// PORTS
//  clk      in  1   system clock
//  reset    in  1   asynchronous reset, active-high
//  pixEn    in  1   pixel tick; counters and pipeline advance only on clk edges with pixEn=1
//  hSync    out 1   horizontal sync, polarity set by H_POL
//  vSync    out 1   vertical sync, polarity set by V_POL
//  valid    out 1   pixel lies in the active area
//  x        out CW  pixel column (raw count, also during blanking)
//  y        out CW  pixel line (raw count, also during blanking)
//  sof      out 1   1-clk strobe when the output presents position (0,0)
//  eol      out 1   1-clk strobe when the output presents x = H_TOTAL-1
//  frameCnt out FW  completed-frame count
// BEHAVIOUR
//  - H_TOTAL = H_AV+H_FP+H_SP+H_BP; V_TOTAL likewise.
//  - hCnt/vCnt: on pixEn, hCnt increments.
//    At hCnt = H_TOTAL-1, hCnt wraps to 0 and vCnt increments.
//    At vCnt = V_TOTAL-1 on that same tick, vCnt wraps to 0.
//  - Decode of the current (hCnt,vCnt):
//    hs active for hCnt in [H_AV+H_FP, H_AV+H_FP+H_SP); vs likewise on vCnt.
//    valid = hCnt<H_AV & vCnt<V_AV.
//  - Pipeline: the decode and the counts enter stage 1 on the same pixEn edge that advances the counters.
//    The outputs show stage DELAY, i.e. position P exactly DELAY pixEn ticks after P was current.
//    With pixEn low, every output except the strobes holds its value.
//  - Strobes: sof/eol = pipeline flag AND pixEn registered one clk.
//    They are high for exactly 1 clk per occurrence, whatever the pixEn duty cycle.
//  - Reset (asynchronous, also mid-frame): counters 0; all pipeline stages clear.
//    Outputs go immediately to: hSync=~H_POL, vSync=~V_POL, valid=0, x=0, y=0, sof=0, eol=0, frameCnt=0.
//    After release, (0,0) reaches the outputs on pixEn tick DELAY, with sof asserted then.
//  - Sync levels use the parameter polarity at all times, including during pipeline fill.
//  - All outputs are registered; no combinational path from pixEn to any output except sof/eol gating.
// CONFIGURATION
//  VGA_FRAME_CNT_EN defined:
//    frameCnt increments (mod 2^FW) on the clk that sof asserts, except the first sof after reset.
//  Not defined:
//    frameCnt tied to 0 and no counter registers are built.
// TESTING
//  1. Default params, pixEn=1, DELAY=1: hSync low for 96 clks starting when x=656; eol every 800 clks.
//  2. Full frame, pixEn=1: sof period 420000 clks.
//     vSync low for 1600 clks (lines 490-491); 307200 valid clks per frame.
//  3. pixEn 1-in-4: x steps once per 4 clks; sof/eol exactly 1 clk wide; sof period 1680000 clks.
//  4. H_POL=1, V_POL=1: syncs idle 0 and pulse 1, with the same widths as test 2.
//  5. reset at x=300,y=200 with DELAY=3: outputs at reset values in the same cycle, no clk edge needed.
//     After release, x=0,y=0,sof=1 on the 3rd pixEn tick.
//  6. VGA_FRAME_CNT_EN, FW=2: frameCnt 0,1,2,3,0 across five frames.
//     Without the macro, frameCnt stays 0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// One pixel advances per pixEn strobe in the system clock domain. Sync,
// valid and coordinates pass through a DELAY-tick pipeline so they line up
// with pipelined video generators. sof/eol are 1-clk strobes.
// Optional feature: define VGA_FRAME_CNT_EN to build the completed-frame
// counter; otherwise frameCnt is tied to 0.
module vga_timing_gen #(
  parameter int H_AV  = 640,
  parameter int H_FP  = 16,
  parameter int H_SP  = 96,
  parameter int H_BP  = 48,
  parameter int V_AV  = 480,
  parameter int V_FP  = 10,
  parameter int V_SP  = 2,
  parameter int V_BP  = 33,
  parameter bit H_POL = 1'b0,
  parameter bit V_POL = 1'b0,
  parameter int DELAY = 1,
  parameter int CW    = 10,
  parameter int FW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pixEn,
  output logic          hSync,
  output logic          vSync,
  output logic          valid,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          sof,
  output logic          eol,
  output logic [FW-1:0] frameCnt
);

  localparam int H_TOTAL = H_AV + H_FP + H_SP + H_BP;
  localparam int V_TOTAL = V_AV + V_FP + V_SP + V_BP;

  // Sync windows expressed as inclusive ranges so the end never overflows CW.
  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_END  = CW'(H_AV);
  localparam logic [CW-1:0] V_ACT_END  = CW'(V_AV);
  localparam logic [CW-1:0] HS_FIRST   = CW'(H_AV + H_FP);
  localparam logic [CW-1:0] HS_LAST    = CW'(H_AV + H_FP + H_SP - 1);
  localparam logic [CW-1:0] VS_FIRST   = CW'(V_AV + V_FP);
  localparam logic [CW-1:0] VS_LAST    = CW'(V_AV + V_FP + V_SP - 1);

  typedef struct packed {
    logic          hs;   // already at output polarity
    logic          vs;   // already at output polarity
    logic          vld;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } stage_t;

  // A cleared stage shows idle syncs, so fill never produces a false pulse.
  localparam stage_t STAGE_RST = '{hs: ~H_POL, vs: ~V_POL, vld: 1'b0, x: '0, y: '0};

  logic [CW-1:0] h_q, h_d, v_q, v_d;
  stage_t        dec;
  logic          dec_sof, dec_eol;
  stage_t        pipe_q [1:DELAY];
  logic          sof_pre, eol_pre;
  logic          sof_q, eol_q;

  // Raster counter next state: advance one pixel per pixEn.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pixEn) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + CW'(1);
      end else begin
        h_d = h_q + CW'(1);
      end
    end
  end

  // Raster counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Decode of the current position, feeding pipeline stage 1.
  always_comb begin
    dec.hs  = ((h_q >= HS_FIRST) && (h_q <= HS_LAST)) ? H_POL : ~H_POL;
    dec.vs  = ((v_q >= VS_FIRST) && (v_q <= VS_LAST)) ? V_POL : ~V_POL;
    dec.vld = (h_q < H_ACT_END) && (v_q < V_ACT_END);
    dec.x   = h_q;
    dec.y   = v_q;
    dec_sof = (h_q == '0) && (v_q == '0);
    dec_eol = (h_q == H_LAST);
  end

  // Output pipeline: shifts one stage per pixel tick, holds otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i <= DELAY; i++) pipe_q[i] <= STAGE_RST;
    end else if (pixEn) begin
      pipe_q[1] <= dec;
      for (int i = 2; i <= DELAY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Strobe flags run one stage behind the data so the registered strobe
  // lands in the same clk as the position it marks.
  generate
    if (DELAY == 1) begin : g_flag_direct
      assign sof_pre = dec_sof;
      assign eol_pre = dec_eol;
    end else begin : g_flag_pipe
      logic [1:0] flg_q [1:DELAY-1];
      // Flag pipeline, same advance rule as the data pipeline.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 1; i <= DELAY - 1; i++) flg_q[i] <= 2'b00;
        end else if (pixEn) begin
          flg_q[1] <= {dec_sof, dec_eol};
          for (int i = 2; i <= DELAY - 1; i++) flg_q[i] <= flg_q[i-1];
        end
      end
      assign {sof_pre, eol_pre} = flg_q[DELAY-1];
    end
  endgenerate

  // Strobes are gated by pixEn so they last one clk at any pixEn duty cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sof_q <= 1'b0;
      eol_q <= 1'b0;
    end else begin
      sof_q <= pixEn & sof_pre;
      eol_q <= pixEn & eol_pre;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [FW-1:0] frame_q;
  logic          seen_sof_q;

  // Completed-frame count: bumps alongside each sof except the first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_q    <= '0;
      seen_sof_q <= 1'b0;
    end else if (pixEn && sof_pre) begin
      seen_sof_q <= 1'b1;
      if (seen_sof_q) frame_q <= frame_q + FW'(1);
    end
  end

  assign frameCnt = frame_q;
`else
  assign frameCnt = '0;
`endif

  assign hSync = pipe_q[DELAY].hs;
  assign vSync = pipe_q[DELAY].vs;
  assign valid = pipe_q[DELAY].vld;
  assign x     = pipe_q[DELAY].x;
  assign y     = pipe_q[DELAY].y;
  assign sof   = sof_q;
  assign eol   = eol_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: two instances on a reduced raster
// (DELAY=1 active-low syncs, DELAY=3 active-high syncs with FW=2).
// A scoreboard queue per instance holds expected positions pushed on each
// pixel tick and popped when they are due at the outputs.
module tb_vga_timing_gen;
  localparam int HAV = 8, HFP = 2, HSP = 3, HBP = 2;
  localparam int VAV = 4, VFP = 1, VSP = 2, VBP = 1;
  localparam int HT = HAV + HFP + HSP + HBP;   // 15
  localparam int VT = VAV + VFP + VSP + VBP;   // 8
  localparam int FRAME = HT * VT;              // 120
  localparam int CW = 6;
  localparam int DA = 1;
  localparam int DB = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pixEn = 1'b0;

  logic          hs_a, vs_a, vld_a, sof_a, eol_a;
  logic [CW-1:0] x_a, y_a;
  logic [7:0]    fc_a;
  logic          hs_b, vs_b, vld_b, sof_b, eol_b;
  logic [CW-1:0] x_b, y_b;
  logic [1:0]    fc_b;

  int tests_run = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_AV(HAV), .H_FP(HFP), .H_SP(HSP), .H_BP(HBP),
    .V_AV(VAV), .V_FP(VFP), .V_SP(VSP), .V_BP(VBP),
    .H_POL(1'b0), .V_POL(1'b0), .DELAY(DA), .CW(CW), .FW(8)
  ) dut_a (
    .clk(clk), .reset(reset), .pixEn(pixEn),
    .hSync(hs_a), .vSync(vs_a), .valid(vld_a), .x(x_a), .y(y_a),
    .sof(sof_a), .eol(eol_a), .frameCnt(fc_a)
  );

  vga_timing_gen #(
    .H_AV(HAV), .H_FP(HFP), .H_SP(HSP), .H_BP(HBP),
    .V_AV(VAV), .V_FP(VFP), .V_SP(VSP), .V_BP(VBP),
    .H_POL(1'b1), .V_POL(1'b1), .DELAY(DB), .CW(CW), .FW(2)
  ) dut_b (
    .clk(clk), .reset(reset), .pixEn(pixEn),
    .hSync(hs_b), .vSync(vs_b), .valid(vld_b), .x(x_b), .y(y_b),
    .sof(sof_b), .eol(eol_b), .frameCnt(fc_b)
  );

  typedef struct {
    logic          hs;
    logic          vs;
    logic          vld;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          sof;
    logic          eol;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t cur_a, cur_b;
  int   hm, vm;
  int   fb_exp;
  bit   fb_seen;

  function automatic exp_t reset_entry(logic hp, logic vp);
    exp_t e;
    e.hs = ~hp; e.vs = ~vp; e.vld = 1'b0;
    e.x = '0; e.y = '0; e.sof = 1'b0; e.eol = 1'b0;
    return e;
  endfunction

  function automatic exp_t pos_entry(int h, int v, logic hp, logic vp);
    exp_t e;
    e.hs  = (h >= HAV + HFP && h < HAV + HFP + HSP) ? hp : ~hp;
    e.vs  = (v >= VAV + VFP && v < VAV + VFP + VSP) ? vp : ~vp;
    e.vld = (h < HAV) && (v < VAV);
    e.x   = CW'(h);
    e.y   = CW'(v);
    e.sof = (h == 0) && (v == 0);
    e.eol = (h == HT - 1);
    return e;
  endfunction

  // Reference model: push the current position on every tick, pop the due one.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      qa.delete();
      qb.delete();
      for (int i = 0; i < DA - 1; i++) qa.push_back(reset_entry(1'b0, 1'b0));
      for (int i = 0; i < DB - 1; i++) qb.push_back(reset_entry(1'b1, 1'b1));
      cur_a = reset_entry(1'b0, 1'b0);
      cur_b = reset_entry(1'b1, 1'b1);
      hm = 0; vm = 0; fb_exp = 0; fb_seen = 1'b0;
    end else if (pixEn) begin
      qa.push_back(pos_entry(hm, vm, 1'b0, 1'b0));
      qb.push_back(pos_entry(hm, vm, 1'b1, 1'b1));
      cur_a = qa.pop_front();
      cur_b = qb.pop_front();
      if (cur_b.sof) begin
        if (fb_seen) fb_exp = (fb_exp + 1) % 4;
        fb_seen = 1'b1;
      end
      if (hm == HT - 1) begin
        hm = 0;
        vm = (vm == VT - 1) ? 0 : vm + 1;
      end else begin
        hm = hm + 1;
      end
    end else begin
      cur_a.sof = 1'b0; cur_a.eol = 1'b0;
      cur_b.sof = 1'b0; cur_b.eol = 1'b0;
    end
  end

  // Scoreboard compare on the falling edge, outside reset.
  always @(negedge clk) begin
    if (!reset) begin
      int fexp;
`ifdef VGA_FRAME_CNT_EN
      fexp = fb_exp;
`else
      fexp = 0;
`endif
      tests_run++;
      if ({hs_a, vs_a, vld_a, x_a, y_a, sof_a, eol_a} !==
          {cur_a.hs, cur_a.vs, cur_a.vld, cur_a.x, cur_a.y, cur_a.sof, cur_a.eol}) begin
        fails++;
        $display("FAIL sb_a t=%0t: got hs=%b vs=%b v=%b x=%0d y=%0d sof=%b eol=%b, want hs=%b vs=%b v=%b x=%0d y=%0d sof=%b eol=%b",
                 $time, hs_a, vs_a, vld_a, x_a, y_a, sof_a, eol_a,
                 cur_a.hs, cur_a.vs, cur_a.vld, cur_a.x, cur_a.y, cur_a.sof, cur_a.eol);
      end
      tests_run++;
      if ({hs_b, vs_b, vld_b, x_b, y_b, sof_b, eol_b, fc_b} !==
          {cur_b.hs, cur_b.vs, cur_b.vld, cur_b.x, cur_b.y, cur_b.sof, cur_b.eol, 2'(fexp)}) begin
        fails++;
        $display("FAIL sb_b t=%0t: got hs=%b vs=%b v=%b x=%0d y=%0d sof=%b eol=%b fc=%0d, want hs=%b vs=%b v=%b x=%0d y=%0d sof=%b eol=%b fc=%0d",
                 $time, hs_b, vs_b, vld_b, x_b, y_b, sof_b, eol_b, fc_b,
                 cur_b.hs, cur_b.vs, cur_b.vld, cur_b.x, cur_b.y, cur_b.sof, cur_b.eol, fexp);
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    pixEn = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({hs_a, vs_a, vld_a, x_a, y_a, sof_a, eol_a, fc_a} !== {1'b1, 1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 8'd0}) begin
      fails++;
      $display("FAIL reset_a: got hs=%b vs=%b v=%b x=%0d y=%0d sof=%b eol=%b fc=%0d, want 1 1 0 0 0 0 0 0",
               hs_a, vs_a, vld_a, x_a, y_a, sof_a, eol_a, fc_a);
    end
    tests_run++;
    if ({hs_b, vs_b, vld_b, x_b, y_b, sof_b, eol_b, fc_b} !== {1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 2'd0}) begin
      fails++;
      $display("FAIL reset_b: got hs=%b vs=%b v=%b x=%0d y=%0d sof=%b eol=%b fc=%0d, want 0 0 0 0 0 0 0 0",
               hs_b, vs_b, vld_b, x_b, y_b, sof_b, eol_b, fc_b);
    end
    reset = 1'b0;
    $display("[TB] reset checked");
  endtask

  task automatic test_raster();
    int hs_cnt_a = 0, vs_cnt_a = 0, vld_cnt_a = 0, eol_cnt_a = 0, sof_cnt_a = 0;
    int hs_cnt_b = 0, vs_cnt_b = 0;
    int last_sof = -1, period = -1;
    logic prev_hs = 1'b1;
    bit   hs_edge_seen = 1'b0;
    int   hs_edge_x = -1;
    @(negedge clk);
    pixEn = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(posedge clk);
      #1;
      if (sof_a) begin
        if (last_sof >= 0) period = i - last_sof;
        last_sof = i;
      end
      if (i >= 2) begin
        if (!hs_edge_seen && prev_hs && !hs_a) begin
          hs_edge_seen = 1'b1;
          hs_edge_x = int'(x_a);
        end
      end
      prev_hs = hs_a;
      if (i >= FRAME) begin
        if (!hs_a) hs_cnt_a++;
        if (!vs_a) vs_cnt_a++;
        if (vld_a) vld_cnt_a++;
        if (eol_a) eol_cnt_a++;
        if (sof_a) sof_cnt_a++;
        if (hs_b) hs_cnt_b++;
        if (vs_b) vs_cnt_b++;
      end
    end
    tests_run++;
    if (hs_cnt_a != HSP * VT) begin fails++; $display("FAIL hsync_width_a: got %0d clks, want %0d", hs_cnt_a, HSP * VT); end
    tests_run++;
    if (vs_cnt_a != VSP * HT) begin fails++; $display("FAIL vsync_width_a: got %0d clks, want %0d", vs_cnt_a, VSP * HT); end
    tests_run++;
    if (vld_cnt_a != HAV * VAV) begin fails++; $display("FAIL valid_count_a: got %0d, want %0d", vld_cnt_a, HAV * VAV); end
    tests_run++;
    if (eol_cnt_a != VT) begin fails++; $display("FAIL eol_count_a: got %0d, want %0d", eol_cnt_a, VT); end
    tests_run++;
    if (sof_cnt_a != 1) begin fails++; $display("FAIL sof_count_a: got %0d, want 1", sof_cnt_a); end
    tests_run++;
    if (period != FRAME) begin fails++; $display("FAIL sof_period_a: got %0d clks, want %0d", period, FRAME); end
    tests_run++;
    if (hs_edge_x != HAV + HFP) begin fails++; $display("FAIL hsync_start_x: got %0d, want %0d", hs_edge_x, HAV + HFP); end
    tests_run++;
    if (hs_cnt_b != HSP * VT) begin fails++; $display("FAIL hsync_high_b: got %0d clks, want %0d", hs_cnt_b, HSP * VT); end
    tests_run++;
    if (vs_cnt_b != VSP * HT) begin fails++; $display("FAIL vsync_high_b: got %0d clks, want %0d", vs_cnt_b, VSP * HT); end
    $display("[TB] raster: hs=%0d vs=%0d valid=%0d eol=%0d sof period=%0d", hs_cnt_a, vs_cnt_a, vld_cnt_a, eol_cnt_a, period);
  endtask

  task automatic test_slow_pixen();
    int last_sof = -1, period = -1;
    int max_sof_w = 0, max_eol_w = 0, sof_w = 0, eol_w = 0;
    for (int i = 0; i < 3 * 4 * FRAME; i++) begin
      @(negedge clk);
      pixEn = (i % 4 == 0);
      @(posedge clk);
      #1;
      sof_w = sof_a ? sof_w + 1 : 0;
      eol_w = eol_b ? eol_w + 1 : 0;
      if (sof_w > max_sof_w) max_sof_w = sof_w;
      if (eol_w > max_eol_w) max_eol_w = eol_w;
      if (sof_a && sof_w == 1) begin
        if (last_sof >= 0) period = i - last_sof;
        last_sof = i;
      end
    end
    tests_run++;
    if (max_sof_w != 1) begin fails++; $display("FAIL slow_sof_width: got %0d clks, want 1", max_sof_w); end
    tests_run++;
    if (max_eol_w != 1) begin fails++; $display("FAIL slow_eol_width: got %0d clks, want 1", max_eol_w); end
    tests_run++;
    if (period != 4 * FRAME) begin fails++; $display("FAIL slow_sof_period: got %0d clks, want %0d", period, 4 * FRAME); end
    $display("[TB] slow pixEn: sof period=%0d", period);
  endtask

  task automatic test_reset_midframe();
    bit found = 1'b0;
    @(negedge clk);
    pixEn = 1'b1;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(posedge clk);
      #1;
      if (x_b == 6'd5 && y_b == 6'd2) found = 1'b1;
    end
    tests_run++;
    if (!found) begin fails++; $display("FAIL midframe_reach: got no (5,2) on dut_b, want it within %0d clks", 2 * FRAME); end
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if ({hs_a, vs_a, vld_a, x_a, y_a, sof_a, eol_a} !== {1'b1, 1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL async_reset_a: got hs=%b vs=%b v=%b x=%0d y=%0d, want 1 1 0 0 0", hs_a, vs_a, vld_a, x_a, y_a);
    end
    tests_run++;
    if ({hs_b, vs_b, vld_b, x_b, y_b, sof_b, eol_b, fc_b} !== {1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 2'd0}) begin
      fails++;
      $display("FAIL async_reset_b: got hs=%b vs=%b v=%b x=%0d y=%0d fc=%0d, want 0 0 0 0 0 0", hs_b, vs_b, vld_b, x_b, y_b, fc_b);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int t = 1; t <= DB; t++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (sof_b !== (t == DB)) begin fails++; $display("FAIL refill_sof_b tick %0d: got %b, want %b", t, sof_b, (t == DB)); end
      if (t == 1) begin
        tests_run++;
        if (sof_a !== 1'b1) begin fails++; $display("FAIL refill_sof_a tick 1: got %b, want 1", sof_a); end
      end
    end
    tests_run++;
    if (x_b !== 6'd0 || y_b !== 6'd0) begin fails++; $display("FAIL refill_pos_b: got (%0d,%0d), want (0,0)", x_b, y_b); end
    $display("[TB] mid-frame reset: refill checked");
  endtask

  task automatic test_frame_cnt();
    int seen_a[$];
    int seen_b[$];
    int want;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    pixEn = 1'b1;
    for (int i = 0; i < 5 * FRAME + DB + 2; i++) begin
      @(posedge clk);
      #1;
      if (sof_a) seen_a.push_back(int'(fc_a));
      if (sof_b) seen_b.push_back(int'(fc_b));
    end
    tests_run++;
    if (seen_b.size() < 5 || seen_a.size() < 5) begin
      fails++;
      $display("FAIL frame_sofs: got %0d/%0d sofs, want at least 5", seen_a.size(), seen_b.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
`ifdef VGA_FRAME_CNT_EN
        want = k % 4;
`else
        want = 0;
`endif
        tests_run++;
        if (seen_b[k] != want) begin fails++; $display("FAIL frame_cnt_b frame %0d: got %0d, want %0d", k, seen_b[k], want); end
`ifdef VGA_FRAME_CNT_EN
        want = k;
`endif
        tests_run++;
        if (seen_a[k] != want) begin fails++; $display("FAIL frame_cnt_a frame %0d: got %0d, want %0d", k, seen_a[k], want); end
      end
    end
    $display("[TB] frame counter: %0d sofs observed", seen_b.size());
  endtask

  initial begin
    test_reset();
    test_raster();
    test_slow_pixen();
    test_reset_midframe();
    test_frame_cnt();
    @(negedge clk);
    pixEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
